apb_bridge_nslave: RTL and testbench

//  Parametrised APB requester bridge: accepts commands on a valid/ready port and runs APB3 transfers
//  to NSLV decoded completers, with PREADY wait states and per-completer PSLVERR. Successor to the fixed
//  2-slave, 9b/8b bridge; sits between the system command source and the slave memories.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_addr_decoder.sv | 33 +++
 rtl/apb_bridge_nslave.sv | 200 ++++++++++++++++++++
 tb/tb_apb_bridge_nslave.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB requester bridge: FSM states, error causes
// and the completer-index width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SLV  = 2'd1;
  localparam logic [1:0] ERR_DEC  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the top address bits to a one-hot completer select.
// Indices at or above NSLV raise dec_err with no select bit.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int NSLV   = 2
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NSLV-1:0]   sel,
  output logic              dec_err
);

  localparam int SEL_W = sel_width(NSLV);

  logic [SEL_W-1:0] idx;
  logic             unused_low;

  assign idx        = addr[ADDR_W-1 -: SEL_W];
  assign unused_low = ^addr;

  always_comb begin
    sel     = '0;
    dec_err = 1'b1;
    for (int i = 0; i < NSLV; i++) begin
      if (32'(idx) == i) begin
        sel[i]  = 1'b1;
        dec_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_bridge_nslave.sv
// APB3 requester bridge: valid/ready commands to NSLV decoded completers.
// Optional ACCESS-phase timeout abort when APB_TIMEOUT_EN is defined.
module apb_bridge_nslave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int NSLV        = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [NSLV-1:0]        PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [NSLV*DATA_W-1:0] PRDATA,
  input  logic [NSLV-1:0]        PREADY,
  input  logic [NSLV-1:0]        PSLVERR
);

  apb_state_e state;
  apb_state_e state_nxt;

  logic [NSLV-1:0]   dec_sel;
  logic              dec_err;
  logic              miss;
  logic              miss_nxt;
  logic              accept;
  logic              tmo;

  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;

  logic [NSLV-1:0]   psel_nxt;
  logic              pen_nxt;
  logic              pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              rv_nxt;
  logic [DATA_W-1:0] rd_nxt;
  logic [1:0]        cause;

  apb_addr_decoder #(
    .ADDR_W (ADDR_W),
    .NSLV   (NSLV)
  ) u_dec (
    .addr    (cmd_addr),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  // Only the selected completer's handshake and data are observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (PSEL[i]) begin
        sel_ready |= PREADY[i];
        sel_err   |= PSLVERR[i];
        sel_rdata |= PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cmd_ready = !PRESET &&
    ((state == APB_IDLE) ||
     ((state == APB_ACCESS) && sel_ready));

  assign accept = cmd_valid && cmd_ready;

`ifdef APB_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign tmo = (state == APB_ACCESS) && !sel_ready &&
    (wait_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == APB_SETUP) begin
      wait_cnt <= '0;
    end else if ((state == APB_ACCESS) && !sel_ready) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;

  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    miss_nxt   = miss;
    psel_nxt   = PSEL;
    pen_nxt    = PENABLE;
    pwrite_nxt = PWRITE;
    paddr_nxt  = PADDR;
    pwdata_nxt = PWDATA;
    rv_nxt     = 1'b0;
    rd_nxt     = '0;
    cause      = ERR_NONE;

    unique case (state)
      APB_IDLE: begin
        state_nxt = APB_IDLE;
      end
      APB_SETUP: begin
        if (miss) begin
          state_nxt = APB_IDLE;
          psel_nxt  = '0;
          rv_nxt    = 1'b1;
          cause     = ERR_DEC;
        end else begin
          state_nxt = APB_ACCESS;
          pen_nxt   = 1'b1;
        end
      end
      APB_ACCESS: begin
        if (sel_ready) begin
          state_nxt = APB_IDLE;
          psel_nxt  = '0;
          pen_nxt   = 1'b0;
          rv_nxt    = 1'b1;
          cause     = sel_err ? ERR_SLV : ERR_NONE;
          if (!PWRITE && !sel_err) begin
            rd_nxt = sel_rdata;
          end
        end else if (tmo) begin
          state_nxt = APB_IDLE;
          psel_nxt  = '0;
          pen_nxt   = 1'b0;
          rv_nxt    = 1'b1;
          cause     = ERR_TMO;
        end
      end
      default: begin
        state_nxt = APB_IDLE;
        psel_nxt  = '0;
        pen_nxt   = 1'b0;
      end
    endcase

    // A new command overrides the return to IDLE (back-to-back).
    if (accept) begin
      state_nxt  = APB_SETUP;
      miss_nxt   = dec_err;
      psel_nxt   = dec_sel;
      pen_nxt    = 1'b0;
      pwrite_nxt = cmd_write;
      paddr_nxt  = cmd_addr;
      pwdata_nxt = cmd_write ? cmd_wdata : '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= APB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      miss      <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      miss      <= miss_nxt;
      PSEL      <= psel_nxt;
      PENABLE   <= pen_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      rsp_valid <= rv_nxt;
      rsp_rdata <= rd_nxt;
      rsp_err   <= rv_nxt && (cause != ERR_NONE);
    end
  end

endmodule

// File: tb/tb_apb_bridge_nslave.sv
// Bench for apb_bridge_nslave: directed scenarios plus randomized transfers
// checked against a transaction-level expectation of the APB protocol.
module tb_apb_bridge_nslave;

  localparam int AW  = 9;
  localparam int DW  = 8;
  localparam int NS  = 2;
  localparam int AW2 = 10;
  localparam int NS2 = 3;
  localparam int TMO = 16;

  logic PCLK = 1'b0;
  logic PRESET;

  always #5 PCLK = ~PCLK;

  logic           cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;
  logic           rsp_valid, rsp_err;
  logic [DW-1:0]  rsp_rdata;
  logic [NS-1:0]  PSEL;
  logic           PENABLE, PWRITE;
  logic [AW-1:0]  PADDR;
  logic [DW-1:0]  PWDATA;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0]  PREADY, PSLVERR;

  logic            b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [AW2-1:0]  b_cmd_addr;
  logic [DW-1:0]   b_cmd_wdata;
  logic            b_rsp_valid, b_rsp_err;
  logic [DW-1:0]   b_rsp_rdata;
  logic [NS2-1:0]  b_PSEL;
  logic            b_PENABLE, b_PWRITE;
  logic [AW2-1:0]  b_PADDR;
  logic [DW-1:0]   b_PWDATA;
  logic [NS2*DW-1:0] b_PRDATA;
  logic [NS2-1:0]  b_PREADY, b_PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  apb_bridge_nslave #(
    .ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .TIMEOUT_CYC(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_bridge_nslave #(
    .ADDR_W(AW2), .DATA_W(DW), .NSLV(NS2), .TIMEOUT_CYC(TMO)
  ) dut3 (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(b_cmd_write), .cmd_addr(b_cmd_addr),
    .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err),
    .PSEL(b_PSEL), .PENABLE(b_PENABLE), .PWRITE(b_PWRITE),
    .PADDR(b_PADDR), .PWDATA(b_PWDATA), .PRDATA(b_PRDATA),
    .PREADY(b_PREADY), .PSLVERR(b_PSLVERR)
  );

  typedef struct {
    logic          ready_offer;
    logic [NS-1:0] s_psel;
    logic          s_pen;
    logic [AW-1:0] s_paddr;
    logic          s_pwrite;
    logic [DW-1:0] s_pwdata;
    int            acc;
    int            lat;
    logic          stable;
    logic          seen;
    logic [DW-1:0] rdata;
    logic          err;
    logic          idle_after;
    logic          pulse_ok;
  } obs_t;

  // Acts as the completer: PREADY rises after `waits` ACCESS cycles.
  task automatic do_xfer(
    input  logic          w,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  int            waits,
    input  logic          err,
    input  logic [DW-1:0] rd,
    output obs_t          o
  );
    int sl;
    sl = int'(addr[AW-1]);
    @(negedge PCLK);
    o.ready_offer = cmd_ready;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    PREADY    = 2'($urandom);
    PSLVERR   = 2'($urandom);
    PRDATA    = 16'($urandom);
    PREADY[sl] = 1'b0;
    PSLVERR[sl] = err;
    PRDATA[sl*DW +: DW] = rd;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    @(negedge PCLK);
    o.s_psel   = PSEL;
    o.s_pen    = PENABLE;
    o.s_paddr  = PADDR;
    o.s_pwrite = PWRITE;
    o.s_pwdata = PWDATA;
    o.acc = 0;
    o.lat = 0;
    o.stable = 1'b1;
    o.seen = 1'b0;
    o.rdata = '0;
    o.err = 1'b0;
    o.idle_after = 1'b0;
    o.pulse_ok = 1'b0;
    for (int n = 0; n < 40 && !o.seen; n++) begin
      @(negedge PCLK);
      o.lat++;
      if (rsp_valid) begin
        o.seen = 1'b1;
        o.rdata = rsp_rdata;
        o.err = rsp_err;
        o.idle_after = (PSEL == '0) && !PENABLE;
      end else if (PENABLE) begin
        o.acc++;
        if (PSEL !== o.s_psel || PADDR !== o.s_paddr ||
            PWRITE !== o.s_pwrite || PWDATA !== o.s_pwdata)
          o.stable = 1'b0;
        PREADY[sl] = (o.acc > waits);
      end
    end
    PREADY = '0;
    @(negedge PCLK);
    o.pulse_ok = !rsp_valid;
  endtask

  task automatic test_reset;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = '0; PSLVERR = '0; PRDATA = '0;
    b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = '0;
    b_cmd_wdata = '0; b_PREADY = '0; b_PSLVERR = '0; b_PRDATA = '0;
    PRESET = 1'b0;
    #2 PRESET = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      n_bad++;
      $display("FAIL reset_apb: got %b %b %b %h %h want zeros",
        PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    n_cmp++;
    if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_rsp: got v=%b d=%h e=%b rdy=%b want 0",
        rsp_valid, rsp_rdata, rsp_err, cmd_ready);
    end
    n_cmp++;
    if ({b_PSEL, b_PENABLE, b_rsp_valid, b_cmd_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_nslv3: got %b %b %b %b want 0",
        b_PSEL, b_PENABLE, b_rsp_valid, b_cmd_ready);
    end
    PRESET = 1'b0;
    @(negedge PCLK);
    n_cmp++;
    if (cmd_ready !== 1'b1 || b_cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b %b want 1 1",
        cmd_ready, b_cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait;
    obs_t o;
    do_xfer(1'b1, 9'h0A5, 8'h3C, 0, 1'b0, 8'hE7, o);
    n_cmp++;
    if (o.s_psel !== 2'b01 || o.s_pen !== 1'b0 ||
        o.s_paddr !== 9'h0A5 || o.s_pwrite !== 1'b1 ||
        o.s_pwdata !== 8'h3C || o.ready_offer !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_setup: got sel=%b en=%b a=%h w=%b d=%h want 01 0 0a5 1 3c",
        o.s_psel, o.s_pen, o.s_paddr, o.s_pwrite, o.s_pwdata);
    end
    n_cmp++;
    if (o.acc !== 1 || o.lat !== 2 || !o.seen) begin
      n_bad++;
      $display("FAIL wr_timing: got acc=%0d lat=%0d seen=%b want 1 2 1",
        o.acc, o.lat, o.seen);
    end
    n_cmp++;
    if (o.err !== 1'b0 || o.rdata !== 8'h00 ||
        !o.idle_after || !o.pulse_ok) begin
      n_bad++;
      $display("FAIL wr_rsp: got err=%b d=%h idle=%b pulse=%b want 0 00 1 1",
        o.err, o.rdata, o.idle_after, o.pulse_ok);
    end
  endtask

  task automatic test_read_wait;
    obs_t o;
    do_xfer(1'b0, 9'h1A5, 8'hFF, 3, 1'b0, 8'h5A, o);
    n_cmp++;
    if (o.s_psel !== 2'b10 || o.s_pwrite !== 1'b0 ||
        o.s_pwdata !== 8'h00) begin
      n_bad++;
      $display("FAIL rd_setup: got sel=%b w=%b d=%h want 10 0 00",
        o.s_psel, o.s_pwrite, o.s_pwdata);
    end
    n_cmp++;
    if (o.acc !== 4 || o.lat !== 5 || !o.stable) begin
      n_bad++;
      $display("FAIL rd_wait: got acc=%0d lat=%0d stable=%b want 4 5 1",
        o.acc, o.lat, o.stable);
    end
    n_cmp++;
    if (o.rdata !== 8'h5A || o.err !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_data: got d=%h e=%b want 5a 0", o.rdata, o.err);
    end
  endtask

  task automatic test_slverr;
    obs_t o;
    do_xfer(1'b0, 9'h033, 8'h00, 1, 1'b1, 8'hA1, o);
    n_cmp++;
    if (o.err !== 1'b1 || o.rdata !== 8'h00 || o.lat !== 3) begin
      n_bad++;
      $display("FAIL slverr: got e=%b d=%h lat=%0d want 1 00 3",
        o.err, o.rdata, o.lat);
    end
  endtask

  task automatic test_random;
    obs_t o;
    logic w, e;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd, exp_rd, exp_wd;
    logic [NS-1:0] exp_sel;
    int wt;
    for (int i = 0; i < 24; i++) begin
      w  = 1'($urandom);
      a  = 9'($urandom);
      wd = 8'($urandom);
      rd = 8'($urandom);
      wt = $urandom_range(0, 4);
      e  = ($urandom_range(0, 3) == 0);
      do_xfer(w, a, wd, wt, e, rd, o);
      exp_sel = 2'(1 << a[AW-1]);
      exp_wd  = w ? wd : 8'h00;
      exp_rd  = (!w && !e) ? rd : 8'h00;
      n_cmp++;
      if (o.s_psel !== exp_sel || o.s_paddr !== a ||
          o.s_pwrite !== w || o.s_pwdata !== exp_wd || o.s_pen !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_setup[%0d]: got sel=%b a=%h d=%h want %b %h %h",
          i, o.s_psel, o.s_paddr, o.s_pwdata, exp_sel, a, exp_wd);
      end
      n_cmp++;
      if (o.acc !== wt + 1 || o.lat !== wt + 2 || !o.stable) begin
        n_bad++;
        $display("FAIL rnd_timing[%0d]: got acc=%0d lat=%0d want %0d %0d",
          i, o.acc, o.lat, wt + 1, wt + 2);
      end
      n_cmp++;
      if (!o.seen || o.rdata !== exp_rd || o.err !== e ||
          !o.idle_after || !o.pulse_ok) begin
        n_bad++;
        $display("FAIL rnd_rsp[%0d]: got d=%h e=%b want %h %b",
          i, o.rdata, o.err, exp_rd, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 9'h012; cmd_wdata = 8'h77;
    PREADY = 2'b11; PSLVERR = 2'b00; PRDATA = {8'h9D, 8'h11};
    @(posedge PCLK);
    #1 cmd_write = 1'b0; cmd_addr = 9'h1C3; cmd_wdata = 8'h55;
    @(negedge PCLK);
    n_cmp++;
    if (PSEL !== 2'b01 || PENABLE !== 1'b0 || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_setup_a: got sel=%b en=%b rdy=%b want 01 0 0",
        PSEL, PENABLE, cmd_ready);
    end
    @(negedge PCLK);
    n_cmp++;
    if (PENABLE !== 1'b1 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_access_a: got en=%b rdy=%b want 1 1",
        PENABLE, cmd_ready);
    end
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    @(negedge PCLK);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00 ||
        PSEL !== 2'b10 || PENABLE !== 1'b0 || PADDR !== 9'h1C3 ||
        PWDATA !== 8'h00) begin
      n_bad++;
      $display("FAIL b2b_handover: got v=%b sel=%b en=%b a=%h want 1 10 0 1c3",
        rsp_valid, PSEL, PENABLE, PADDR);
    end
    @(negedge PCLK);
    @(negedge PCLK);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h9D || PSEL !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_rsp_b: got v=%b d=%h sel=%b want 1 9d 00",
        rsp_valid, rsp_rdata, PSEL);
    end
    PREADY = '0;
  endtask

  task automatic test_decode_err;
    @(negedge PCLK);
    b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 10'h3F0;
    b_PREADY = 3'b111; b_PSLVERR = 3'b000; b_PRDATA = 24'($urandom);
    @(posedge PCLK);
    #1 b_cmd_valid = 1'b0;
    @(negedge PCLK);
    n_cmp++;
    if (b_PSEL !== 3'b000 || b_PENABLE !== 1'b0 || b_rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL dec_setup: got sel=%b en=%b v=%b want 000 0 0",
        b_PSEL, b_PENABLE, b_rsp_valid);
    end
    @(negedge PCLK);
    n_cmp++;
    if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b1 ||
        b_rsp_rdata !== 8'h00 || b_PENABLE !== 1'b0 || b_PSEL !== 3'b000) begin
      n_bad++;
      $display("FAIL dec_rsp: got v=%b e=%b d=%h en=%b want 1 1 00 0",
        b_rsp_valid, b_rsp_err, b_rsp_rdata, b_PENABLE);
    end
    @(negedge PCLK);
    n_cmp++;
    if (b_rsp_valid !== 1'b0 || b_cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL dec_after: got v=%b rdy=%b want 0 1",
        b_rsp_valid, b_cmd_ready);
    end
    b_cmd_valid = 1'b1; b_cmd_addr = 10'h2B4;
    b_PSLVERR = 3'b011; b_PRDATA = {8'hC6, 8'h12, 8'h34};
    @(posedge PCLK);
    #1 b_cmd_valid = 1'b0;
    @(negedge PCLK);
    n_cmp++;
    if (b_PSEL !== 3'b100) begin
      n_bad++;
      $display("FAIL dec_slave2_sel: got %b want 100", b_PSEL);
    end
    @(negedge PCLK);
    @(negedge PCLK);
    n_cmp++;
    if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b0 || b_rsp_rdata !== 8'hC6) begin
      n_bad++;
      $display("FAIL dec_slave2_rsp: got v=%b e=%b d=%h want 1 0 c6",
        b_rsp_valid, b_rsp_err, b_rsp_rdata);
    end
    b_PREADY = '0;
  endtask

  task automatic test_timeout;
`ifdef APB_TIMEOUT_EN
    obs_t o;
    do_xfer(1'b0, 9'h144, 8'h00, 1000, 1'b0, 8'h6B, o);
    n_cmp++;
    if (o.acc !== TMO || o.lat !== TMO + 1 || o.err !== 1'b1 ||
        o.rdata !== 8'h00 || !o.idle_after) begin
      n_bad++;
      $display("FAIL timeout: got acc=%0d lat=%0d e=%b d=%h want %0d %0d 1 00",
        o.acc, o.lat, o.err, o.rdata, TMO, TMO + 1);
    end
`endif
  endtask

  task automatic test_reset_mid;
    obs_t o;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h155;
    PREADY = 2'b00;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    n_cmp++;
    if (PENABLE !== 1'b1 || PSEL !== 2'b10) begin
      n_bad++;
      $display("FAIL rst_mid_access: got en=%b sel=%b want 1 10",
        PENABLE, PSEL);
    end
    #1 PRESET = 1'b1;
    #1;
    n_cmp++;
    if (PSEL !== 2'b00 || PENABLE !== 1'b0 || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_drop: got sel=%b en=%b rdy=%b want 00 0 0",
        PSEL, PENABLE, cmd_ready);
    end
    @(negedge PCLK);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_norsp: got v=%b want 0", rsp_valid);
    end
    PRESET = 1'b0;
    do_xfer(1'b0, 9'h0F0, 8'h00, 2, 1'b0, 8'h2E, o);
    n_cmp++;
    if (!o.seen || o.rdata !== 8'h2E || o.err !== 1'b0 ||
        o.lat !== 4 || o.s_psel !== 2'b01) begin
      n_bad++;
      $display("FAIL rst_mid_next: got d=%h e=%b lat=%0d sel=%b want 2e 0 4 01",
        o.rdata, o.err, o.lat, o.s_psel);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_random();
    test_decode_err();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
